// File: rtl/cpu_pkg.sv
// Shared MIPS instruction-field definitions for IF/ID/EX stages.
// Pure constants, no logic; no latency.
// No flow control of its own.
package cpu_pkg;

   // Fixed MIPS field positions, reused by every decoder downstream
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_LSB = 6;
   localparam int IMM_W     = 16;
   localparam int JT_W      = 26;
   localparam int REG_IDX_W = 5;

   // All-zero word is sll $0,$0,0, i.e. the canonical NOP bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_fields.sv
// Slices a MIPS instruction into decode fields, forcing a NOP when invalid.
// Purely combinational, zero latency.
// No flow control; follows whatever entry the caller presents.
module if_id_fields
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 32
) (
   input  logic                 i_valid,
   input  logic [INSTR_W-1:0]   i_instr,
   output logic [INSTR_W-1:0]   o_instr,
   output logic [REG_IDX_W-1:0] o_rs,
   output logic [REG_IDX_W-1:0] o_rt,
   output logic [REG_IDX_W-1:0] o_rd,
   output logic [REG_IDX_W-1:0] o_shamt,
   output logic [IMM_W-1:0]     o_imm16,
   output logic [JT_W-1:0]      o_jt
);

   logic [INSTR_W-1:0] w_instr;

   // Replace the word with a NOP bubble so stale storage never leaks out
   always_comb begin
      w_instr = INSTR_W'(NOP_INSTR);
      if (i_valid) begin
         w_instr = i_instr;
      end
   end

   assign o_instr = w_instr;
   assign o_rs    = w_instr[RS_LSB    +: REG_IDX_W];
   assign o_rt    = w_instr[RT_LSB    +: REG_IDX_W];
   assign o_rd    = w_instr[RD_LSB    +: REG_IDX_W];
   assign o_shamt = w_instr[SHAMT_LSB +: REG_IDX_W];
   assign o_imm16 = w_instr[0 +: IMM_W];
   assign o_jt    = w_instr[0 +: JT_W];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry in-order IF/ID queue presenting the head with pre-split MIPS fields.
// Latency: one cycle from push to visibility on out_*; no pass-through when empty.
// Backpressure: in_ready = not-full (registered state only, no path from out_ready).
module if_id_queue
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int DEPTH   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PC_W-1:0]              in_pc,
   input  logic [PC_W-1:0]              in_pc_plus4,
   input  logic [INSTR_W-1:0]           in_instr,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [PC_W-1:0]              out_pc,
   output logic [PC_W-1:0]              out_pc_plus4,
   output logic [INSTR_W-1:0]           out_instr,
   output logic [REG_IDX_W-1:0]         out_rs,
   output logic [REG_IDX_W-1:0]         out_rt,
   output logic [REG_IDX_W-1:0]         out_rd,
   output logic [REG_IDX_W-1:0]         out_shamt,
   output logic [IMM_W-1:0]             out_imm16,
   output logic [JT_W-1:0]              out_jt,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PC_W-1:0]    r_mem_pc    [DEPTH];
   logic [PC_W-1:0]    r_mem_pc4   [DEPTH];
   logic [INSTR_W-1:0] r_mem_instr [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic w_full;
   logic w_nonempty;
   logic w_push;
   logic w_pop;

   assign w_full     = (r_count == FULL_CNT);
   assign w_nonempty = (r_count != '0);
   // Full means refuse even if decode pops this cycle, keeping out_ready off in_ready
   assign w_push     = in_valid & ~w_full;
   assign w_pop      = w_nonempty & out_ready;

   // Pointer and occupancy update; reset and flush both empty the queue
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage written only by an accepted push; a dropped push leaves it untouched
   always_ff @(posedge clk) begin
      if (w_push && !reset && !flush) begin
         r_mem_pc[r_wr_ptr]    <= in_pc;
         r_mem_pc4[r_wr_ptr]   <= in_pc_plus4;
         r_mem_instr[r_wr_ptr] <= in_instr;
      end
   end

   // Head PC values gated to zero while empty so decode sees a clean bubble
   always_comb begin
      out_pc       = '0;
      out_pc_plus4 = '0;
      if (w_nonempty) begin
         out_pc       = r_mem_pc[r_rd_ptr];
         out_pc_plus4 = r_mem_pc4[r_rd_ptr];
      end
   end

   if_id_fields #(
      .INSTR_W (INSTR_W)
   ) u_fields (
      .i_valid (w_nonempty),
      .i_instr (r_mem_instr[r_rd_ptr]),
      .o_instr (out_instr),
      .o_rs    (out_rs),
      .o_rt    (out_rt),
      .o_rd    (out_rd),
      .o_shamt (out_shamt),
      .o_imm16 (out_imm16),
      .o_jt    (out_jt)
   );

   assign in_ready  = ~w_full;
   assign out_valid = w_nonempty;
   assign count     = r_count;

endmodule
